// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants for the decode-stage operand scoreboard: bypass channel layout
// ({we, waddr, wdata} per channel) and stall vector bit positions.
package id_operand_scoreboard_pkg;

    localparam int REG_W      = 5;
    localparam int NUM_REGS   = 32;
    localparam int BYP_CTRL_W = 1 + REG_W;

    localparam int BYP_WDATA_OFF = 0;

    localparam int STALL_ID = 0;
    localparam int STALL_EX = 1;

    function automatic int byp_wd(input int xlen);
        return BYP_CTRL_W + xlen;
    endfunction

    function automatic int byp_waddr_off(input int xlen);
        return xlen;
    endfunction

    function automatic int byp_we_off(input int xlen);
        return xlen + REG_W;
    endfunction

endpackage

// File: rtl/id_operand_scoreboard_late_stage_tracker.sv
// Tracks which pipeline stages (EX onward) hold a result that cannot be forwarded yet.
// A held stage behind a moving stage becomes a bubble; a flush clears every entry.
module id_operand_scoreboard_late_stage_tracker
    import id_operand_scoreboard_pkg::*;
#(
    parameter int LATE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LATE_DEPTH:0]   stall,
    input  logic                  br_e,
    input  logic                  iss_in,
    output logic [LATE_DEPTH-1:0] late_v
);

    logic [LATE_DEPTH-1:0] late_v_q;
    logic [LATE_DEPTH-1:0] late_v_d;
    logic [LATE_DEPTH:0]   shift_src;

    // Entry k (stored at bit k-1) loads from shift_src[k-1]: the issue bit for k=1.
    assign shift_src = {late_v_q, iss_in};

    always_comb begin
        late_v_d = late_v_q;
        for (int k = 1; k <= LATE_DEPTH; k++) begin
            if (br_e || (stall[k-1] && !stall[k])) begin
                late_v_d[k-1] = 1'b0;
            end else if (!stall[k-1]) begin
                late_v_d[k-1] = shift_src[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            late_v_q <= '0;
        end else begin
            late_v_q <= late_v_d;
        end
    end

    assign late_v = late_v_q;

endmodule

// File: rtl/id_operand_scoreboard.sv
// Decode-stage operand forwarding and hazard detection over NUM_BYP bypass channels.
// Define LONG_SCOREBOARD_EN to add the per-register busy scoreboard for the long-latency unit.
module id_operand_scoreboard
    import id_operand_scoreboard_pkg::*;
#(
    parameter int NUM_BYP    = 4,
    parameter int LATE_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LATE_DEPTH:0]          stall,
    input  logic                         br_e,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic                         rs1_used,
    input  logic                         rs2_used,
    input  logic [XLEN-1:0]              rdata1,
    input  logic [XLEN-1:0]              rdata2,
    input  logic                         iss_we,
    input  logic [4:0]                   iss_waddr,
    input  logic                         iss_late,
    input  logic                         iss_long,
    input  logic [NUM_BYP*(6+XLEN)-1:0]  byp_bus,
    input  logic                         long_done,
    input  logic [4:0]                   long_waddr,
    output logic [XLEN-1:0]              src1_fwd,
    output logic [XLEN-1:0]              src2_fwd,
    output logic                         stallreq_id
);

    localparam int BW        = byp_wd(XLEN);
    localparam int WADDR_OFF = byp_waddr_off(XLEN);
    localparam int WE_OFF    = byp_we_off(XLEN);

    logic [NUM_BYP-1:0]    ch_we;
    logic [REG_W-1:0]      ch_waddr [NUM_BYP];
    logic [XLEN-1:0]       ch_wdata [NUM_BYP];
    logic [LATE_DEPTH-1:0] late_v;
    logic [NUM_BYP-1:0]    late_ext;
    logic                  iss_fire;
    logic                  late_kind;
    logic                  late1;
    logic                  late2;
    logic                  late_hz;
    logic                  busy_hz;

    for (genvar i = 0; i < NUM_BYP; i++) begin : g_ch
        assign ch_wdata[i] = byp_bus[i*BW + BYP_WDATA_OFF +: XLEN];
        assign ch_waddr[i] = byp_bus[i*BW + WADDR_OFF +: REG_W];
        assign ch_we[i]    = byp_bus[i*BW + WE_OFF];
    end

    assign iss_fire = !stall[STALL_ID] && !br_e;

    id_operand_scoreboard_late_stage_tracker #(
        .LATE_DEPTH(LATE_DEPTH)
    ) u_late (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .br_e  (br_e),
        .iss_in(iss_fire && late_kind && iss_we),
        .late_v(late_v)
    );

    // Channels beyond the tracked depth always carry valid data.
    assign late_ext = NUM_BYP'(late_v);

    // Scan oldest to youngest so the lowest-index match wins; its late bit decides the hazard.
    always_comb begin
        src1_fwd = rdata1;
        src2_fwd = rdata2;
        late1    = 1'b0;
        late2    = 1'b0;
        for (int c = NUM_BYP - 1; c >= 0; c--) begin
            if (ch_we[c] && (ch_waddr[c] == rs1) && (rs1 != 5'd0)) begin
                src1_fwd = ch_wdata[c];
                late1    = late_ext[c];
            end
            if (ch_we[c] && (ch_waddr[c] == rs2) && (rs2 != 5'd0)) begin
                src2_fwd = ch_wdata[c];
                late2    = late_ext[c];
            end
        end
    end

    assign late_hz = (late1 && rs1_used) || (late2 && rs2_used);

`ifdef LONG_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // A same-cycle set overrides the clear; x0 can never become busy.
    always_comb begin
        busy_d = busy_q;
        if (long_done) begin
            busy_d[long_waddr] = 1'b0;
        end
        if (iss_fire && iss_long && iss_we && (iss_waddr != 5'd0)) begin
            busy_d[iss_waddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign late_kind = iss_late;
    assign busy_hz   = (busy_q[rs1] && rs1_used) || (busy_q[rs2] && rs2_used) ||
                       (busy_q[iss_waddr] && iss_we);
`else
    logic unused_long;

    assign unused_long = ^{long_done, long_waddr};
    assign late_kind   = iss_late || iss_long;
    assign busy_hz     = 1'b0;
`endif

    assign stallreq_id = rst_n && !br_e && (late_hz || busy_hz);

endmodule
